// File: rtl/mux_n_rr.sv
// N-to-1 streaming mux with a one-entry output register. The channel is chosen
// either by the sel input (MODE=0) or by a round-robin arbiter (MODE=1).

module mux_n_rr_lane #(
  parameter int SW = 2,
  parameter int K  = 0
) (
  input  logic          rst_n,
  input  logic          load_en,
  input  logic          gnt_vld,
  input  logic [SW-1:0] gnt,
  output logic          ready
);
  // Reset gating keeps every ready low while the block is held in reset.
  assign ready = rst_n && load_en && gnt_vld && (gnt == SW'(K));
endmodule

module mux_n_rr #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  parameter  int MODE = 1,
  localparam int SW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_ch
);

  logic [N-1:0][W-1:0] lane_data;
  logic [SW-1:0]       ptr, gnt;
  logic [SW:0]         idx;
  logic                gnt_vld, load_en, xfer;

  assign lane_data = in_data;
  assign load_en   = !out_valid || out_ready;
  assign xfer      = rst_n && load_en && gnt_vld;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    if (MODE == 0) begin
      // Compare against each legal index so an out-of-range sel simply never matches.
      for (int k = 0; k < N; k++) begin
        if (SW'(k) == sel && in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt     = SW'(k);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = {1'b0, ptr} + (SW+1)'(i);
        if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
        if (!gnt_vld && in_valid[idx[SW-1:0]]) begin
          gnt_vld = 1'b1;
          gnt     = idx[SW-1:0];
        end
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    mux_n_rr_lane #(.SW(SW), .K(k)) u_lane (
      .rst_n   (rst_n),
      .load_en (load_en),
      .gnt_vld (gnt_vld),
      .gnt     (gnt),
      .ready   (in_ready[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= lane_data[gnt];
        out_ch    <= gnt;
        if (MODE != 0) ptr <= (gnt == SW'(N-1)) ? '0 : gnt + SW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_rr.sv
// Directed bench: fixed-select (N=4 and N=3) and round-robin (N=4) instances
// driven side by side from one clock and one reset.

module tb_mux_n_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u0: N=4, MODE=0
  logic [31:0] in_data0 = {8'h33, 8'h22, 8'h11, 8'h00};
  logic [3:0]  in_valid0 = 4'b1111, in_ready0;
  logic [1:0]  sel0 = 2'd0, out_ch0;
  logic [7:0]  out_data0;
  logic        out_valid0, out_ready0 = 1'b1;

  // u1: N=4, MODE=1
  logic [31:0] in_data1 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
  logic [3:0]  in_valid1 = 4'b1111, in_ready1;
  logic [1:0]  sel1 = 2'd0, out_ch1;
  logic [7:0]  out_data1;
  logic        out_valid1, out_ready1 = 1'b1;

  // u2: N=3, MODE=0
  logic [23:0] in_data2 = {8'h5C, 8'h5B, 8'h5A};
  logic [2:0]  in_valid2 = 3'b111, in_ready2;
  logic [1:0]  sel2 = 2'd3, out_ch2;
  logic [7:0]  out_data2;
  logic        out_valid2, out_ready2 = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  mux_n_rr #(.N(4), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .sel(sel0), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ch(out_ch0));

  mux_n_rr #(.N(4), .W(8), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .sel(sel1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_ch(out_ch1));

  mux_n_rr #(.N(3), .W(8), .MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .sel(sel2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_ch(out_ch2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state with every channel valid: nothing may be offered.
    #3;
    chk("rst_rdy1", in_ready1, 4'b0000);
    chk("rst_rdy0", in_ready0, 4'b0000);
    chk("rst_ov1",  out_valid1, 1'b0);
    chk("rst_od1",  out_data1, 8'h00);
    chk("rst_och1", out_ch1, 2'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Fixed select on u0 and round-robin on u1 in parallel; u2 sits at sel=3.
    for (int i = 0; i < 8; i++) begin
      sel0 = 2'(i % 4);
      #1;
      chk("u0_rdy", in_ready0, 4'b0001 << (i % 4));
      chk("u2_rdy", in_ready2, 3'b000);
      tick();
      chk("u0_data", out_data0, 8'h11 * (i % 4));
      chk("u0_ch",   out_ch0, i % 4);
      chk("u1_ch",   out_ch1, i % 4);
      chk("u1_data", out_data1, 8'hA0 + 8'h11 * (i % 4));
      chk("u1_ov",   out_valid1, 1'b1);
      chk("u2_ov",   out_valid2, 1'b0);
      chk("u2_data", out_data2, 8'h00);
      chk("u2_ch",   out_ch2, 2'd0);
    end

    // u1 ptr=0: only ch2, then ch0+ch3 -> 2, 3, 0.
    in_valid1 = 4'b0100;
    #1;
    chk("rr_rdy_a", in_ready1, 4'b0100);
    tick();
    chk("rr_ch_a", out_ch1, 2'd2);
    in_valid1 = 4'b1001;
    #1;
    chk("rr_rdy_b", in_ready1, 4'b1000);
    tick();
    chk("rr_ch_b", out_ch1, 2'd3);
    tick();
    chk("rr_ch_c", out_ch1, 2'd0);
    chk("rr_dat_c", out_data1, 8'hA0);

    // Backpressure for three cycles, then release (ptr=1).
    in_valid1 = 4'b1111;
    out_ready1 = 1'b0;
    #1;
    chk("bp_rdy", in_ready1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_data", out_data1, 8'hA0);
      chk("bp_ch",   out_ch1, 2'd0);
      chk("bp_ov",   out_valid1, 1'b1);
      chk("bp_rdy2", in_ready1, 4'b0000);
    end
    out_ready1 = 1'b1;
    #1;
    chk("rel_rdy", in_ready1, 4'b0010);
    tick();
    chk("rel_ch",   out_ch1, 2'd1);
    chk("rel_data", out_data1, 8'hB1);

    // Drain with no requests: valid drops, payload holds.
    in_valid1 = 4'b0000;
    tick();
    chk("drain_ov",   out_valid1, 1'b0);
    chk("drain_data", out_data1, 8'hB1);
    chk("drain_ch",   out_ch1, 2'd1);

    // Reload (ptr=2) then asynchronous reset pulse between edges.
    in_valid1 = 4'b1111;
    tick();
    chk("pre_rst_ch", out_ch1, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov1",  out_valid1, 1'b0);
    chk("arst_od1",  out_data1, 8'h00);
    chk("arst_och1", out_ch1, 2'd0);
    chk("arst_rdy1", in_ready1, 4'b0000);
    chk("arst_ov0",  out_valid0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", in_ready1, 4'b0001);
    tick();
    chk("post_rst_ch",   out_ch1, 2'd0);
    chk("post_rst_data", out_data1, 8'hA0);
    chk("post_rst_ov",   out_valid1, 1'b1);

    // u0: selected channel not valid -> no grant, valid drops.
    in_valid0 = 4'b1011;
    sel0 = 2'd2;
    #1;
    chk("u0_inv_rdy", in_ready0, 4'b0000);
    tick();
    chk("u0_inv_ov", out_valid0, 1'b0);

    // u2: legal select on N=3, then back to sel=3.
    sel2 = 2'd2;
    #1;
    chk("u2_sel2_rdy", in_ready2, 3'b100);
    tick();
    chk("u2_sel2_data", out_data2, 8'h5C);
    chk("u2_sel2_ch",   out_ch2, 2'd2);
    chk("u2_sel2_ov",   out_valid2, 1'b1);
    sel2 = 2'd3;
    #1;
    chk("u2_sel3_rdy", in_ready2, 3'b000);
    tick();
    chk("u2_sel3_ov",   out_valid2, 1'b0);
    chk("u2_sel3_data", out_data2, 8'h5C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
